multi_rope_display: RTL and testbench
=====================================

MULTI_ROPE_DISPLAY -- requirements
Module: multi_rope_display

Interface
REQ-001 Parameter NUM_ROPES, default 4, meaning the number of independent ropes (1..8).
REQ-002 Parameter ROPE_X0, default 80, meaning the left X of rope 0 at zero swing.
REQ-003 Parameter ROPE_SPACING, default 120, meaning the X pitch between adjacent rope bases.
REQ-004 Parameter ROPE_TOP_Y, default 64, meaning the Y of the rope anchor row.
REQ-005 Parameter ROPE_LEN_LOG2, default 8, meaning rope length = 2**ROPE_LEN_LOG2 lines.
REQ-006 Parameter ROPE_W, default 4, meaning the rope width in pixels.
REQ-007 Parameter SWING_MAX, default 15, meaning the maximum |bottom offset| in pixels (1..31).
REQ-008 Parameter STEP_FRAMES, default 4, meaning frames per one-pixel swing step (>=1).
REQ-009 Parameter ROPE_COLOR, default 8'hA4, meaning the RGB332 rope colour.
REQ-010 clk  in  1  system clock; the only clock.
REQ-011 resetN  in  1  asynchronous, active-low reset.
REQ-012 startOfFrame  in  1  one-cycle pulse per VGA frame.
REQ-013 pixelX  in  11  current VGA column.
REQ-014 pixelY  in  11  current VGA row.
REQ-015 dirToggle  in  NUM_ROPES  per-rope pulse requesting a swing reversal.
REQ-016 ropeDR  out  1  rope pixel drawing request.
REQ-017 ropeRGB  out  8  rope pixel colour.
REQ-018 ropeIdx  out  3  index of the rope drawn at this pixel.

Function
REQ-019 Each rope i SHALL hold signed 6-bit offset[i], dir[i] (1 = right), frame counter cnt[i], and pending flag pend[i].
REQ-020 Any dirToggle[i] high on a clock edge SHALL set pend[i]; multiple pulses within one frame SHALL still yield one reversal.
REQ-021 On startOfFrame with cnt[i] < STEP_FRAMES-1, cnt[i] SHALL increment; offset, dir and pend SHALL be unchanged.
REQ-022 On startOfFrame with cnt[i] = STEP_FRAMES-1, cnt[i] SHALL clear, pend[i] SHALL clear, and d = dir[i] XOR pend[i] SHALL be evaluated.
REQ-023 In that step, if d = right and offset < SWING_MAX, offset SHALL increment and dir SHALL become right; if offset = SWING_MAX, offset SHALL decrement and dir SHALL become left (mirror rule at -SWING_MAX).
REQ-024 Bound reversal SHALL take precedence over pend, so |offset| never exceeds SWING_MAX.
REQ-025 A dirToggle pulse coincident with the stepping startOfFrame SHALL be applied at that step.
REQ-026 Rope i SHALL cover pixel (x,y) when ROPE_TOP_Y <= y < ROPE_TOP_Y + 2**ROPE_LEN_LOG2 and base_i + s <= x < base_i + s + ROPE_W, where base_i = ROPE_X0 + i*ROPE_SPACING and s = (offset[i] * (y - ROPE_TOP_Y)) arithmetic-shifted right by ROPE_LEN_LOG2.
REQ-027 Geometry arithmetic SHALL be signed, at least 18 bits; negative x SHALL never match.
REQ-028 ropeDR, ropeRGB and ropeIdx SHALL be registered: one clock latency from pixelX/pixelY.
REQ-029 With overlapping ropes, the lowest index SHALL win; ropeRGB = ROPE_COLOR when ropeDR = 1, else 8'h00; ropeIdx = 0 when ropeDR = 0.

Reset
REQ-030 resetN low SHALL immediately clear all offset, cnt and pend, set all dir to right, and drive ropeDR = 0, ropeRGB = 8'h00, ropeIdx = 0.
REQ-031 Reset mid-frame SHALL discard pending toggles; counting restarts from 0 at the first startOfFrame after release.

Configuration
REQ-032 Macro ROPE_HOLD_EN, when defined, SHALL add input ropeHold[NUM_ROPES-1:0]; while ropeHold[i] = 1, cnt[i] and offset[i] freeze, and pend[i] still latches for application at the first step after release.
REQ-033 Without ROPE_HOLD_EN, the port SHALL be absent and behaviour SHALL be identical to ropeHold = 0.

Verification
REQ-034 Reset, then 4 startOfFrame pulses (STEP_FRAMES=4) -> offset[0] = +1, dir right.
REQ-035 Run 64 steps -> offset peaks at +15, then 14, ..., reaches -15, reverses; never exceeds 15.
REQ-036 offset[1] = +5, dir right, dirToggle[1] pulsed three times in one frame before a step -> offset[1] = +4, dir left.
REQ-037 offset[0] = +15, dirToggle[0] pulsed at the step -> offset = +14, dir left (bound wins, no overshoot).
REQ-038 offset[2] = +8, pixelY = ROPE_TOP_Y + 128, pixelX = 320 + 4 -> ropeDR = 1, ropeIdx = 2, ropeRGB = 8'hA4 one clock later; pixelX = 323 -> ropeDR = 0.
REQ-039 ROPE_HOLD_EN defined, ropeHold[0] = 1 for 12 frames with a dirToggle[0] pulse -> offset[0] unchanged; first step after release reverses direction.

Source files
------------

// File: rtl/multi_rope_display.sv
// multi_rope_display: NUM_ROPES pendulum ropes stepped once per STEP_FRAMES frames; ropeHold input exists only with ROPE_HOLD_EN.
// ropeDR/ropeRGB/ropeIdx are registered, 1 clk after pixelX/pixelY; no backpressure, the pixel stream is free-running.
module multi_rope_display #(
    parameter int          NUM_ROPES     = 4,
    parameter int          ROPE_X0       = 80,
    parameter int          ROPE_SPACING  = 120,
    parameter int          ROPE_TOP_Y    = 64,
    parameter int          ROPE_LEN_LOG2 = 8,
    parameter int          ROPE_W        = 4,
    parameter int          SWING_MAX     = 15,
    parameter int          STEP_FRAMES   = 4,
    parameter logic [7:0]  ROPE_COLOR    = 8'hA4
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic [NUM_ROPES-1:0] dirToggle,
`ifdef ROPE_HOLD_EN
    input  logic [NUM_ROPES-1:0] ropeHold,
`endif
    output logic                 ropeDR,
    output logic [7:0]           ropeRGB,
    output logic [2:0]           ropeIdx
);

    localparam int CW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(STEP_FRAMES - 1);
    localparam logic signed [5:0]  SMAX     = 6'(SWING_MAX);
    localparam logic signed [23:0] TOP_Y    = 24'(ROPE_TOP_Y);
    localparam logic signed [23:0] LEN      = 24'(2 ** ROPE_LEN_LOG2);
    localparam logic signed [23:0] RW       = 24'(ROPE_W);

    logic signed [5:0]     offset_q [NUM_ROPES];
    logic signed [5:0]     offset_d [NUM_ROPES];
    logic [CW-1:0]         cnt_q    [NUM_ROPES];
    logic [CW-1:0]         cnt_d    [NUM_ROPES];
    logic [NUM_ROPES-1:0]  dir_q, dir_d;
    logic [NUM_ROPES-1:0]  pend_q, pend_d;
    logic [NUM_ROPES-1:0]  hold;

    logic                  dr_q, dr_d;
    logic [7:0]            rgb_q, rgb_d;
    logic [2:0]            idx_q, idx_d;

`ifdef ROPE_HOLD_EN
    assign hold = ropeHold;
`else
    assign hold = '0;
`endif

    // A toggle arriving on the stepping edge is folded into d directly rather than via pend.
    always_comb begin
        dir_d  = dir_q;
        pend_d = pend_q | dirToggle;
        for (int i = 0; i < NUM_ROPES; i++) begin
            offset_d[i] = offset_q[i];
            cnt_d[i]    = cnt_q[i];
            if (startOfFrame && !hold[i]) begin
                if (cnt_q[i] != CNT_LAST) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else begin
                    cnt_d[i]  = '0;
                    pend_d[i] = 1'b0;
                    if (dir_q[i] ^ (pend_q[i] | dirToggle[i])) begin
                        if (offset_q[i] < SMAX) begin
                            offset_d[i] = offset_q[i] + 6'sd1;
                            dir_d[i]    = 1'b1;
                        end else begin
                            offset_d[i] = offset_q[i] - 6'sd1;
                            dir_d[i]    = 1'b0;
                        end
                    end else begin
                        if (offset_q[i] > -SMAX) begin
                            offset_d[i] = offset_q[i] - 6'sd1;
                            dir_d[i]    = 1'b0;
                        end else begin
                            offset_d[i] = offset_q[i] + 6'sd1;
                            dir_d[i]    = 1'b1;
                        end
                    end
                end
            end
        end
    end

    logic signed [23:0] xpos, yrel, prod, left;
    logic               y_in;

    // Scan from the highest index down so the lowest covering rope is the one kept.
    always_comb begin
        dr_d  = 1'b0;
        idx_d = '0;
        prod  = '0;
        left  = '0;
        xpos  = $signed({13'd0, pixelX});
        yrel  = $signed({13'd0, pixelY}) - TOP_Y;
        y_in  = (yrel >= 24'sd0) && (yrel < LEN);
        for (int i = NUM_ROPES - 1; i >= 0; i--) begin
            prod = $signed({{18{offset_q[i][5]}}, offset_q[i]}) * yrel;
            left = 24'(ROPE_X0 + i * ROPE_SPACING) + (prod >>> ROPE_LEN_LOG2);
            if (y_in && (xpos >= left) && (xpos < left + RW)) begin
                dr_d  = 1'b1;
                idx_d = 3'(i);
            end
        end
        rgb_d = dr_d ? ROPE_COLOR : 8'h00;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_ROPES; i++) begin
                offset_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            dir_q  <= '1;
            pend_q <= '0;
            dr_q   <= 1'b0;
            rgb_q  <= 8'h00;
            idx_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_ROPES; i++) begin
                offset_q[i] <= offset_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            dir_q  <= dir_d;
            pend_q <= pend_d;
            dr_q   <= dr_d;
            rgb_q  <= rgb_d;
            idx_q  <= idx_d;
        end
    end

    assign ropeDR  = dr_q;
    assign ropeRGB = rgb_q;
    assign ropeIdx = idx_q;

endmodule

// File: tb/tb_multi_rope_display.sv
// Directed bench for multi_rope_display with default parameters; hold checks compile in with ROPE_HOLD_EN.
module tb_multi_rope_display;

    logic        clk          = 1'b0;
    logic        resetN       = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX       = '0;
    logic [10:0] pixelY       = '0;
    logic [3:0]  dirToggle    = '0;
`ifdef ROPE_HOLD_EN
    logic [3:0]  ropeHold     = '0;
`endif
    logic        ropeDR;
    logic [7:0]  ropeRGB;
    logic [2:0]  ropeIdx;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_rope_display dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .dirToggle    (dirToggle),
`ifdef ROPE_HOLD_EN
        .ropeHold     (ropeHold),
`endif
        .ropeDR       (ropeDR),
        .ropeRGB      (ropeRGB),
        .ropeIdx      (ropeIdx)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_rope(input int i, input int exp_off, input int exp_dir, input string tag);
        int off;
        off = $signed(dut.offset_q[i]);
        check($sformatf("%s off%0d", tag, i), off, exp_off);
        check($sformatf("%s dir%0d", tag, i), int'(dut.dir_q[i]), exp_dir);
    endtask

    task automatic check_pix(input int x, input int y, input int dr, input int idx, input string tag);
        @(negedge clk);
        pixelX = 11'(x);
        pixelY = 11'(y);
        @(negedge clk);
        check({tag, " dr"},  int'(ropeDR),  dr);
        check({tag, " idx"}, int'(ropeIdx), idx);
        check({tag, " rgb"}, int'(ropeRGB), dr ? 'hA4 : 0);
    endtask

    task automatic sof_tog(input logic [3:0] mask);
        @(negedge clk);
        startOfFrame = 1'b1;
        dirToggle    = mask;
        @(negedge clk);
        startOfFrame = 1'b0;
        dirToggle    = '0;
    endtask

    task automatic sof_n(input int n);
        for (int k = 0; k < n; k++) sof_tog(4'b0000);
    endtask

    task automatic toggle(input logic [3:0] mask);
        @(negedge clk);
        dirToggle = mask;
        @(negedge clk);
        dirToggle = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Free swing from reset is a triangle wave of period 60 steps: 0..15..-15..0.
    function automatic int tri_off(input int k);
        int m;
        m = k % 60;
        if (m <= 15)      return m;
        else if (m <= 45) return 30 - m;
        else              return m - 60;
    endfunction

    function automatic int tri_dir(input int k);
        int m;
        m = k % 60;
        return (m >= 16 && m <= 45) ? 0 : 1;
    endfunction

    initial begin
        pixelX = 11'd80;
        pixelY = 11'd64;
        repeat (2) @(negedge clk);
        check("reset dr",  int'(ropeDR),  0);
        check("reset rgb", int'(ropeRGB), 0);
        check("reset idx", int'(ropeIdx), 0);
        check_rope(0, 0, 1, "reset");
        resetN = 1'b1;
        @(negedge clk);
        check("top pixel dr",  int'(ropeDR),  1);
        check("top pixel rgb", int'(ropeRGB), 'hA4);

        // Asynchronous clear: outputs drop without waiting for a clock edge.
        resetN = 1'b0;
        #1;
        check("async dr",  int'(ropeDR),  0);
        check("async rgb", int'(ropeRGB), 0);
        @(negedge clk);
        resetN = 1'b1;

        sof_n(3);
        check_rope(0, 0, 1, "3 frames");
        sof_n(1);
        check_rope(0, 1, 1, "step1");

        for (int k = 2; k <= 64; k++) begin
            sof_n(4);
            check_rope(0, tri_off(k), tri_dir(k), $sformatf("step%0d", k));
            if (k == 8) begin
                check_pix(324, 192, 1, 2, "r2 left edge");
                check_pix(323, 192, 0, 0, "r2 left-1");
                check_pix(327, 192, 1, 2, "r2 right edge");
                check_pix(328, 192, 0, 0, "r2 right+1");
                check_pix(444, 192, 1, 3, "r3 left edge");
                check_pix(87, 319, 1, 0, "r0 last line");
                check_pix(88, 320, 0, 0, "below rope");
                check_pix(80, 63, 0, 0, "above rope");
            end
            if (k == 45) begin
                check_pix(65, 319, 1, 0, "neg left edge");
                check_pix(64, 319, 0, 0, "neg left-1");
            end
        end
        check_rope(3, 4, 1, "step64");

        // Multiple toggles in one frame reverse once; bound wins over a toggle.
        do_reset();
        sof_n(20);
        check_rope(1, 5, 1, "pre toggle");
        sof_n(3);
        toggle(4'b0010);
        toggle(4'b0010);
        toggle(4'b0010);
        sof_n(1);
        check_rope(1, 4, 0, "triple toggle");
        check_rope(0, 6, 1, "untoggled");
        sof_n(36);
        check_rope(0, 15, 1, "at bound");
        check_rope(1, -5, 0, "r1 down");
        sof_n(3);
        sof_tog(4'b0011);
        check_rope(0, 14, 0, "bound+toggle");
        check_rope(1, -4, 1, "coincident toggle");
        check_rope(2, 14, 0, "bound only");

        // Reset mid-frame discards pending toggles and restarts frame counting.
        sof_n(2);
        toggle(4'b0100);
        do_reset();
        check_rope(2, 0, 1, "after reset");
        sof_n(3);
        check_rope(2, 0, 1, "restart 3 frames");
        sof_n(1);
        check_rope(2, 1, 1, "pend discarded");

`ifdef ROPE_HOLD_EN
        @(negedge clk);
        ropeHold = 4'b0001;
        sof_n(5);
        toggle(4'b0001);
        sof_n(7);
        check_rope(0, 1, 1, "held");
        check_rope(1, 4, 1, "not held");
        @(negedge clk);
        ropeHold = 4'b0000;
        sof_n(3);
        check_rope(0, 1, 1, "released 3");
        sof_n(1);
        check_rope(0, 0, 0, "held toggle");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
